// File: rtl/byte_serializer_if.sv
// Handshake and data bundle between the switch-side producer and the serializer.
// The master drives the load request and word; the serializer drives the serial outputs.
interface byte_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic             cont;
  logic [WIDTH-1:0] din;
  logic             dout;
  logic             dvalid;
  logic             busy;
  logic             done;

  modport master (
    output load, cont, din,
    input  dout, dvalid, busy, done
  );

  modport slave (
    input  load, cont, din,
    output dout, dvalid, busy, done
  );
endinterface

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter feeding the Moore sequence detector: load handshake,
// optional inter-word gap, continuous repeat mode, all outputs registered.
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic              clk,
  input  logic              clr,
  byte_serializer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_L   = 4'(GAP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  state_t           state_p0, state_nxt;
  logic [WIDTH-1:0] sreg_p0, sreg_nxt;
  logic [CNT_W-1:0] bitcnt_p0, bitcnt_nxt;
  logic [3:0]       gapcnt_p0, gapcnt_nxt;
  logic             dout_p1, dout_nxt;
  logic             vld_p1, vld_nxt;
  logic             busy_p1, busy_nxt;
  logic             done_p1, done_nxt;
  logic             start;
  logic             take;

  assign start = bus.load | bus.cont;

  // Next-state and next-output logic. The first bit is driven on the capture edge,
  // so bitcnt counts bits already presented and the register holds only the rest.
  always_comb begin
    state_nxt  = state_p0;
    sreg_nxt   = sreg_p0;
    bitcnt_nxt = bitcnt_p0;
    gapcnt_nxt = gapcnt_p0;
    dout_nxt   = 1'b0;
    vld_nxt    = 1'b0;
    done_nxt   = 1'b0;
    take       = 1'b0;

    case (state_p0)
      ST_IDLE: begin
        if (start) take = 1'b1;
      end

      ST_SHIFT: begin
        if (bitcnt_p0 != LAST) begin
          dout_nxt   = first_bit(sreg_p0);
          sreg_nxt   = shift_one(sreg_p0);
          bitcnt_nxt = bitcnt_p0 + 1'b1;
          vld_nxt    = 1'b1;
          done_nxt   = (bitcnt_p0 == LAST_M1);
        end else if (GAP_L != 4'd0) begin
          state_nxt  = ST_GAP;
          gapcnt_nxt = GAP_L;
          bitcnt_nxt = '0;
        end else if (start) begin
          take = 1'b1;
        end else begin
          state_nxt  = ST_IDLE;
          bitcnt_nxt = '0;
        end
      end

      ST_GAP: begin
        if (gapcnt_p0 == 4'd1) begin
          gapcnt_nxt = 4'd0;
          if (start) take = 1'b1;
          else       state_nxt = ST_IDLE;
        end else begin
          gapcnt_nxt = gapcnt_p0 - 4'd1;
        end
      end

      default: begin
        state_nxt  = ST_IDLE;
        sreg_nxt   = '0;
        bitcnt_nxt = '0;
        gapcnt_nxt = 4'd0;
      end
    endcase

    if (take) begin
      state_nxt  = ST_SHIFT;
      sreg_nxt   = shift_one(bus.din);
      dout_nxt   = first_bit(bus.din);
      vld_nxt    = 1'b1;
      bitcnt_nxt = CNT_W'(1);
      gapcnt_nxt = 4'd0;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Stage p0: control state and shift register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_p0  <= ST_IDLE;
      sreg_p0   <= '0;
      bitcnt_p0 <= '0;
      gapcnt_p0 <= 4'd0;
    end else begin
      state_p0  <= state_nxt;
      sreg_p0   <= sreg_nxt;
      bitcnt_p0 <= bitcnt_nxt;
      gapcnt_p0 <= gapcnt_nxt;
    end
  end

  // Stage p1: registered serial outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      dout_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      dout_p1 <= dout_nxt;
      vld_p1  <= vld_nxt;
      busy_p1 <= busy_nxt;
      done_p1 <= done_nxt;
    end
  end

  assign bus.dout   = dout_p1;
  assign bus.dvalid = vld_p1;
  assign bus.busy   = busy_p1;
  assign bus.done   = done_p1;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: three instances (MSB/GAP0, LSB/GAP0, MSB/GAP2)
// share one stimulus; the instance under test is selected for observation.
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       load = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] din = 8'h00;
  int         checks = 0;
  int         failures = 0;
  int         sel = 0;

  byte_serializer_if #(.WIDTH(8)) if_a ();
  byte_serializer_if #(.WIDTH(8)) if_b ();
  byte_serializer_if #(.WIDTH(8)) if_c ();

  assign if_a.load = load;  assign if_a.cont = cont;  assign if_a.din = din;
  assign if_b.load = load;  assign if_b.cont = cont;  assign if_b.din = din;
  assign if_c.load = load;  assign if_c.cont = cont;  assign if_c.din = din;

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u_a (.clk(clk), .clr(clr), .bus(if_a));
  byte_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) u_b (.clk(clk), .clr(clr), .bus(if_b));
  byte_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(2)) u_c (.clk(clk), .clr(clr), .bus(if_c));

  always #5 clk = ~clk;

  logic o_dout, o_vld, o_busy, o_done;
  always_comb begin
    o_dout = if_a.dout;  o_vld = if_a.dvalid;  o_busy = if_a.busy;  o_done = if_a.done;
    case (sel)
      1: begin o_dout = if_b.dout; o_vld = if_b.dvalid; o_busy = if_b.busy; o_done = if_b.done; end
      2: begin o_dout = if_c.dout; o_vld = if_c.dvalid; o_busy = if_c.busy; o_done = if_c.done; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input int i, input logic b, input logic d);
    chk($sformatf("%s_dout[%0d]", tag, i), 32'(o_dout), 32'(b));
    chk($sformatf("%s_vld[%0d]", tag, i), 32'(o_vld), 32'd1);
    chk($sformatf("%s_busy[%0d]", tag, i), 32'(o_busy), 32'd1);
    chk($sformatf("%s_done[%0d]", tag, i), 32'(o_done), 32'(d));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout"}, 32'(o_dout), 32'd0);
    chk({tag, "_vld"}, 32'(o_vld), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  task automatic do_reset();
    clr = 1'b1; load = 1'b0; cont = 1'b0;
    step();
    step();
    clr = 1'b0;
  endtask

  logic [7:0] w;

  initial begin
    // reset state of all three instances
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      chk_idle($sformatf("rst%0d", s));
    end
    clr = 1'b0;
    step();

    // Test 1: MSB first, 8'b10110010
    sel = 0;
    w = 8'b1011_0010;
    din = w; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_bit("t1", i, w[7-i], i == 7);
      step();
    end
    chk_idle("t1_end");

    // Test 2: LSB first, 8'hA5
    do_reset();
    sel = 1;
    w = 8'hA5;
    din = w; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_bit("t2", i, w[i], i == 7);
      step();
    end
    chk_idle("t2_end");

    // Test 3: continuous, GAP=0, 3 back-to-back words of 8'hF0
    do_reset();
    sel = 0;
    w = 8'hF0;
    din = w; cont = 1'b1;
    step();
    for (int i = 0; i < 24; i++) begin
      chk_bit("t3", i, w[7-(i%8)], (i % 8) == 7);
      if (i == 23) cont = 1'b0;
      step();
    end
    chk_idle("t3_end");

    // Test 4: continuous, GAP=2, 8'h81, period 10
    do_reset();
    sel = 2;
    w = 8'h81;
    din = w; cont = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      if ((i % 10) < 8) begin
        chk_bit("t4", i, w[7-(i%10)], (i % 10) == 7);
      end else begin
        chk($sformatf("t4_gap_dout[%0d]", i), 32'(o_dout), 32'd0);
        chk($sformatf("t4_gap_vld[%0d]", i), 32'(o_vld), 32'd0);
        chk($sformatf("t4_gap_busy[%0d]", i), 32'(o_busy), 32'd1);
        chk($sformatf("t4_gap_done[%0d]", i), 32'(o_done), 32'd0);
      end
      if (i == 19) cont = 1'b0;
      step();
    end
    chk_idle("t4_end");

    // Test 5: load and din change during bit 4 do not disturb the word in flight
    do_reset();
    sel = 0;
    din = 8'hFF; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_bit("t5", i, 1'b1, i == 7);
      if (i == 3) begin
        load = 1'b1;
        din = 8'h00;
      end
      step();
    end
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_bit("t5_next", i, 1'b0, i == 7);
      step();
    end
    chk_idle("t5_end");

    // Test 6: clr with load during bit 5 aborts the word, then a clean 8'h3C
    sel = 0;
    din = 8'hFF; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_bit("t6_pre", i, 1'b1, 1'b0);
      step();
    end
    clr = 1'b1; load = 1'b1;
    step();
    chk_idle("t6_clr");
    clr = 1'b0; load = 1'b0;
    step();
    chk_idle("t6_after");
    w = 8'h3C;
    din = w; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_bit("t6", i, w[7-i], i == 7);
      step();
    end
    chk_idle("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
Upstream stage for the Moore sequence detector. It captures a parallel word from the board switches and emits it one bit per clock on a serial line, with valid, busy and done flags. Its serial output drives the detector's serial input directly. It replaces free-running parallel-to-serial shifting with a load handshake, a configurable inter-word gap, and a continuous-repeat mode.

Parameters:
WIDTH, 8, word width in bits (2..16)
MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = shift out din[0] first
GAP, 0, idle cycles inserted between consecutive words (0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  synchronous active-high reset; priority over all other inputs
load  input  1  request to capture din; sampled on rising edge
cont  input  1  continuous mode: automatically reload din after each word
din  input  WIDTH  parallel word (switches)
dout  output  1  serial data bit
dvalid  output  1  high while dout carries a word bit
busy  output  1  high in SHIFT and GAP states
done  output  1  one-cycle pulse coincident with the last bit of a word

Behaviour:
- Interface: one clock, clk. Reset clr is synchronous and active-high.
- Reset: if clr=1 at a rising edge, then on the next cycle:
  - state = IDLE
  - dout = 0, dvalid = 0, busy = 0, done = 0
  - shift register = 0, bit counter = 0, gap counter = 0
  - a clr asserted mid-word aborts the word; no done pulse is produced.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States are IDLE, SHIFT and GAP.
- IDLE:
  - dout = 0, dvalid = 0, busy = 0.
  - Capture condition: load=1 or cont=1 at edge N. On capture, din is latched, the bit counter is cleared and the state moves to SHIFT.
  - The first bit appears on dout with dvalid=1 in cycle N+1. Load-to-first-bit latency is 1 cycle.
- SHIFT:
  - Each cycle presents one bit: dout = selected end of the shift register, and dvalid = 1.
  - The register shifts toward the output end and zero-fills; the bit counter increments.
  - Bits of a word captured at edge N occupy cycles N+1 .. N+WIDTH.
  - done = 1 only in cycle N+WIDTH.
  - load or din changes during SHIFT do not alter the word in flight.
- End of word (edge after the last-bit cycle):
  - GAP > 0: go to GAP and load the gap counter with GAP.
  - GAP = 0 and (load or cont) sampled high at that edge: capture the new din and stay in SHIFT. Words run back-to-back with no idle cycle.
  - Otherwise: go to IDLE.
- GAP:
  - dout = 0, dvalid = 0, busy = 1.
  - The counter decrements each cycle and the block stays in GAP for exactly GAP cycles.
  - At the edge where the counter reaches 1:
    - if load or cont = 1: capture din and go to SHIFT;
    - else: go to IDLE.
  - A load seen earlier in GAP is not remembered; only the sample at that exit edge counts.
- The bit counter width is ceil(log2(WIDTH+1)). The gap counter is 4 bits.
- Simultaneous clr and load: clr wins and din is not captured.
- cont held high: words repeat indefinitely with a period of WIDTH+GAP cycles. din is re-sampled at every capture.
- Deasserting cont mid-word finishes the current word, then the normal end-of-word rule applies.
- In IDLE, dout = 0. This gives the downstream detector no spurious 1s.

Test Plan:
1. MSB_FIRST=1, GAP=0, din=8'b10110010, load pulsed for 1 cycle at edge N -> dout = 1,0,1,1,0,0,1,0 in cycles N+1..N+8. dvalid high over the same cycles. done only at N+8. IDLE at N+9 with busy=0.
2. MSB_FIRST=0, din=8'hA5, single load -> dout = 1,0,1,0,0,1,0,1 (LSB first). done at the 8th bit.
3. GAP=0, cont=1, din=8'hF0 held for 3 words -> 24 consecutive dvalid cycles with pattern 11110000 repeated. done at bits 8, 16 and 24. busy never drops.
4. GAP=2, cont=1, din=8'h81 -> 8 valid bits, then 2 cycles with dvalid=0 and dout=0, then the next word. The repeat period is 10 cycles.
5. load asserted and din changed to 8'h00 during bit 4 of word 8'hFF -> the remaining bits are all 1. The new word starts only if load is high at the end-of-word edge.
6. clr asserted during bit 5 of a word, together with load=1 -> the next cycle has all outputs 0, state IDLE and no done pulse. After clr drops, load with din=8'h3C -> a clean 00111100 sequence.
